// File: rtl/burst_mem_responder.sv
// burst_mem_responder
//
// Small line-oriented memory model that answers whole-line read and write
// requests as four 64-bit beats. Storage is 2**s_index lines of 256 bits,
// cleared by reset. A request is accepted in IDLE, waits `latency` idle
// cycles, streams four beats with resp_o high, spends one cycle in DONE and
// returns to IDLE.
//
// Parameters
//   s_index  log2 of the number of 256-bit lines
//   latency  idle cycles between acceptance and the first beat (0..15)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   read_i     line read request, held until the final beat
//   write_i    line write request, held until the final beat
//   address_i  line address; index = address_i[s_index+4:5], other bits ignored
//   burst_i    write beat data, sampled on each write beat
//   burst_o    read beat data, zero outside read beats (registered)
//   resp_o     beat strobe, high for four cycles per transaction (registered)

module burst_mem_responder #(
    parameter int s_index = 3,
    parameter int latency = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [31:0] address_i,
    input  logic [63:0] burst_i,
    output logic [63:0] burst_o,
    output logic        resp_o
);

    localparam int         lines     = 2 ** s_index;
    localparam logic [3:0] wait_load = (latency > 0) ? 4'(latency - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BEAT,
        DONE
    } state_t;

    state_t               state;
    state_t               state_n;
    logic                 op_write;
    logic                 op_write_n;
    logic [s_index-1:0]   idx;
    logic [s_index-1:0]   idx_n;
    logic [1:0]           beat;
    logic [1:0]           beat_n;
    logic [3:0]           wait_cnt;
    logic [3:0]           wait_cnt_n;
    logic [63:0]          rd_word;
    logic [255:0]         mem [lines];

    // Address bits outside the line index are deliberately ignored so that
    // lines alias; collecting them here keeps them visibly accounted for.
    logic unused_addr;
    assign unused_addr = ^{address_i[31:s_index+5], address_i[4:0]};

    // Next-state logic. Everything defaults to holding its value; only IDLE
    // looks at the request inputs, so once a transaction is accepted the
    // requester can do anything without disturbing it. When both read and
    // write are raised together the read wins. The beat counter is 2 bits
    // and naturally wraps to 0 exactly as the last beat finishes.
    always_comb begin
        state_n    = state;
        op_write_n = op_write;
        idx_n      = idx;
        beat_n     = beat;
        wait_cnt_n = wait_cnt;
        case (state)
            IDLE: begin
                if (read_i || write_i) begin
                    op_write_n = write_i && !read_i;
                    idx_n      = address_i[s_index+4:5];
                    beat_n     = 2'd0;
                    wait_cnt_n = wait_load;
                    state_n    = (latency == 0) ? BEAT : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_n = BEAT;
                end else begin
                    wait_cnt_n = wait_cnt - 4'd1;
                end
            end
            BEAT: begin
                beat_n = beat + 2'd1;
                if (beat == 2'd3) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // The read word for the upcoming cycle is fetched using the next-state
    // index and beat so that burst_o can be registered yet still line up
    // with resp_o, even with zero latency.
    always_comb begin
        rd_word = mem[idx_n][{beat_n, 6'd0} +: 64];
    end

    // State register, storage and registered outputs. Reset clears every
    // line, which is also what discards any partially written burst. A
    // write beat lands in the line at the edge that ends that beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_write <= 1'b0;
            idx      <= '0;
            beat     <= 2'd0;
            wait_cnt <= 4'd0;
            resp_o   <= 1'b0;
            burst_o  <= 64'd0;
            for (int i = 0; i < lines; i++) begin
                mem[i] <= 256'd0;
            end
        end else begin
            state    <= state_n;
            op_write <= op_write_n;
            idx      <= idx_n;
            beat     <= beat_n;
            wait_cnt <= wait_cnt_n;
            if (state == BEAT && op_write) begin
                mem[idx][{beat, 6'd0} +: 64] <= burst_i;
            end
            resp_o  <= (state_n == BEAT);
            burst_o <= (state_n == BEAT && !op_write_n) ? rd_word : 64'd0;
        end
    end

endmodule
